// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: control-bundle bit layout and base opcodes.
package riscv_pipe_pkg;

  localparam int unsigned CTRL_W = 8;

  localparam int unsigned CTRL_ALU_SRC    = 7;
  localparam int unsigned CTRL_MEM_TO_REG = 6;
  localparam int unsigned CTRL_REG_WRITE  = 5;
  localparam int unsigned CTRL_MEM_READ   = 4;
  localparam int unsigned CTRL_MEM_WRITE  = 3;
  localparam int unsigned CTRL_BRANCH     = 2;
  localparam int unsigned CTRL_ALU_OP_HI  = 1;
  localparam int unsigned CTRL_ALU_OP_LO  = 0;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // rs2 is a real source for register-register ops and for store data.
  function automatic logic ctrl_uses_rs2(input logic [CTRL_W-1:0] ctrl);
    return ~ctrl[CTRL_ALU_SRC] | ctrl[CTRL_MEM_WRITE];
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection between the instruction in EX and the one in ID.
module hazard_detect #(
  parameter int unsigned RA_W = 5
) (
  input  logic            ex_valid,
  input  logic            ex_mem_read,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            id_valid,
  input  logic            id_uses_rs2,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            flush,
  output logic            stall
);

  logic load_use;

  always_comb begin
    load_use = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid &
               ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));
    // A flush kills the ID instruction, so there is nothing to stall for.
    stall = load_use & ~flush;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and
// saturating bubble/flush event counters.
module id_ex_stage
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RA_W  = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [RA_W-1:0]   id_rs1,
  input  logic [RA_W-1:0]   id_rs2,
  input  logic [RA_W-1:0]   id_rd,
  input  logic [2:0]        id_funct3,
  input  logic              id_funct7_5,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [RA_W-1:0]   ex_rs1,
  output logic [RA_W-1:0]   ex_rs2,
  output logic [RA_W-1:0]   ex_rd,
  output logic [2:0]        ex_funct3,
  output logic              ex_funct7_5,
  output logic              pc_write,
  output logic              ifid_write,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic              ex_valid_q, ex_valid_d;
  logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
  logic [XLEN-1:0]   ex_pc_q, ex_pc_d;
  logic [XLEN-1:0]   ex_rs1_data_q, ex_rs1_data_d;
  logic [XLEN-1:0]   ex_rs2_data_q, ex_rs2_data_d;
  logic [XLEN-1:0]   ex_imm_q, ex_imm_d;
  logic [RA_W-1:0]   ex_rs1_q, ex_rs1_d;
  logic [RA_W-1:0]   ex_rs2_q, ex_rs2_d;
  logic [RA_W-1:0]   ex_rd_q, ex_rd_d;
  logic [2:0]        ex_funct3_q, ex_funct3_d;
  logic              ex_funct7_5_q, ex_funct7_5_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              stall;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
  endfunction

  hazard_detect #(
    .RA_W (RA_W)
  ) u_hazard_detect (
    .ex_valid    (ex_valid_q),
    .ex_mem_read (ex_ctrl_q[CTRL_MEM_READ]),
    .ex_rd       (ex_rd_q),
    .id_valid    (id_valid),
    .id_uses_rs2 (ctrl_uses_rs2(id_ctrl)),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .flush       (flush),
    .stall       (stall)
  );

  always_comb begin
    // Upstream must be free to advance while reset is held.
    pc_write   = reset | ~(stall | hold);
    ifid_write = pc_write;
  end

  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_ctrl_d     = ex_ctrl_q;
    ex_pc_d       = ex_pc_q;
    ex_rs1_data_d = ex_rs1_data_q;
    ex_rs2_data_d = ex_rs2_data_q;
    ex_imm_d      = ex_imm_q;
    ex_rs1_d      = ex_rs1_q;
    ex_rs2_d      = ex_rs2_q;
    ex_rd_d       = ex_rd_q;
    ex_funct3_d   = ex_funct3_q;
    ex_funct7_5_d = ex_funct7_5_q;
    bubble_cnt_d  = bubble_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    if (!hold) begin
      // Operand fields are don't-care under a bubble, so they always load.
      ex_pc_d       = id_pc;
      ex_rs1_data_d = id_rs1_data;
      ex_rs2_data_d = id_rs2_data;
      ex_imm_d      = id_imm;
      ex_rs1_d      = id_rs1;
      ex_rs2_d      = id_rs2;
      ex_rd_d       = id_rd;
      ex_funct3_d   = id_funct3;
      ex_funct7_5_d = id_funct7_5;
      if (flush) begin
        ex_valid_d  = 1'b0;
        ex_ctrl_d   = '0;
        flush_cnt_d = sat_inc(flush_cnt_q);
      end else if (stall) begin
        ex_valid_d   = 1'b0;
        ex_ctrl_d    = '0;
        bubble_cnt_d = sat_inc(bubble_cnt_q);
      end else begin
        ex_valid_d = id_valid;
        ex_ctrl_d  = id_valid ? id_ctrl : '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q    <= 1'b0;
      ex_ctrl_q     <= '0;
      ex_pc_q       <= '0;
      ex_rs1_data_q <= '0;
      ex_rs2_data_q <= '0;
      ex_imm_q      <= '0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_rd_q       <= '0;
      ex_funct3_q   <= '0;
      ex_funct7_5_q <= 1'b0;
      bubble_cnt_q  <= '0;
      flush_cnt_q   <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_ctrl_q     <= ex_ctrl_d;
      ex_pc_q       <= ex_pc_d;
      ex_rs1_data_q <= ex_rs1_data_d;
      ex_rs2_data_q <= ex_rs2_data_d;
      ex_imm_q      <= ex_imm_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_rd_q       <= ex_rd_d;
      ex_funct3_q   <= ex_funct3_d;
      ex_funct7_5_q <= ex_funct7_5_d;
      bubble_cnt_q  <= bubble_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_ctrl     = ex_ctrl_q;
  assign ex_pc       = ex_pc_q;
  assign ex_rs1_data = ex_rs1_data_q;
  assign ex_rs2_data = ex_rs2_data_q;
  assign ex_imm      = ex_imm_q;
  assign ex_rs1      = ex_rs1_q;
  assign ex_rs2      = ex_rs2_q;
  assign ex_rd       = ex_rd_q;
  assign ex_funct3   = ex_funct3_q;
  assign ex_funct7_5 = ex_funct7_5_q;
  assign bubble_cnt  = bubble_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a vector table of ID-stage inputs with
// hand-computed EX outputs, plus saturation and asynchronous-reset sequences.
module tb_id_ex_stage;

  localparam logic [7:0] R  = 8'b00100010;
  localparam logic [7:0] LW = 8'b11110000;
  localparam logic [7:0] SW = 8'b10001000;

  logic        clk = 1'b0;
  logic        reset, hold, flush, id_valid;
  logic [7:0]  id_ctrl;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_funct3;
  logic        id_funct7_5;

  logic        ex_valid, pc_write, ifid_write, ex_funct7_5;
  logic [7:0]  ex_ctrl;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_funct3;
  logic [15:0] bubble_cnt, flush_cnt;

  // Narrow-counter copy sharing the same stimulus, used to reach saturation.
  logic        s_ex_valid, s_pc_write, s_ifid_write, s_ex_funct7_5;
  logic [7:0]  s_ex_ctrl;
  logic [31:0] s_ex_pc, s_ex_rs1_data, s_ex_rs2_data, s_ex_imm;
  logic [4:0]  s_ex_rs1, s_ex_rs2, s_ex_rd;
  logic [2:0]  s_ex_funct3;
  logic [2:0]  s_bubble_cnt, s_flush_cnt;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .RA_W(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_ctrl(id_ctrl), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_funct3(id_funct3), .id_funct7_5(id_funct7_5),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7_5(ex_funct7_5),
    .pc_write(pc_write), .ifid_write(ifid_write), .bubble_cnt(bubble_cnt),
    .flush_cnt(flush_cnt)
  );

  id_ex_stage #(.XLEN(32), .RA_W(5), .CNT_W(3)) dut_small (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_ctrl(id_ctrl), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_funct3(id_funct3), .id_funct7_5(id_funct7_5),
    .ex_valid(s_ex_valid), .ex_ctrl(s_ex_ctrl), .ex_pc(s_ex_pc),
    .ex_rs1_data(s_ex_rs1_data), .ex_rs2_data(s_ex_rs2_data), .ex_imm(s_ex_imm),
    .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2), .ex_rd(s_ex_rd), .ex_funct3(s_ex_funct3),
    .ex_funct7_5(s_ex_funct7_5), .pc_write(s_pc_write), .ifid_write(s_ifid_write),
    .bubble_cnt(s_bubble_cnt), .flush_cnt(s_flush_cnt)
  );

  typedef struct {
    logic       hold, flush, vld;
    logic [7:0] ctrl;
    logic [4:0] rs1, rs2, rd;
    logic       exp_pcw;
    logic       exp_v;
    logic [7:0] exp_ctrl;
    logic       chk_data;
    int         exp_bub, exp_fl;
  } vec_t;

  vec_t vecs[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic add(input logic h, input logic f, input logic v, input logic [7:0] c,
                     input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                     input logic pcw, input logic ev, input logic [7:0] ec,
                     input logic cd, input int bub, input int fl);
    vec_t t;
    t.hold = h; t.flush = f; t.vld = v; t.ctrl = c; t.rs1 = r1; t.rs2 = r2; t.rd = rd;
    t.exp_pcw = pcw; t.exp_v = ev; t.exp_ctrl = ec; t.chk_data = cd;
    t.exp_bub = bub; t.exp_fl = fl;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pc_of(input int i);
    return 32'h1000 + 32'(i) * 4;
  endfunction

  task automatic drive(input vec_t t, input int i);
    logic [31:0] p;
    p           = pc_of(i);
    hold        = t.hold;
    flush       = t.flush;
    id_valid    = t.vld;
    id_ctrl     = t.ctrl;
    id_rs1      = t.rs1;
    id_rs2      = t.rs2;
    id_rd       = t.rd;
    id_pc       = p;
    id_rs1_data = {16'hA5A5, p[15:0]};
    id_rs2_data = ~p;
    id_imm      = p ^ 32'h00FF00FF;
    id_funct3   = p[4:2];
    id_funct7_5 = p[2];
  endtask

  initial begin
    int          di;
    logic [31:0] ep;
    vec_t        t;

    // hold, flush, vld, ctrl, rs1, rs2, rd | pcw, ex_valid, ex_ctrl, chk_data, bub, fl
    add(0, 0, 1, R,   3, 4,  5,  1, 1, R,  1, 0, 0);  // plain R-type pass-through
    add(0, 0, 1, LW,  1, 0,  5,  1, 1, LW, 1, 0, 0);  // lw x5
    add(0, 0, 1, R,   1, 5,  6,  0, 0, 0,  0, 1, 0);  // add uses x5 via rs2: bubble
    add(0, 0, 1, R,   1, 5,  6,  1, 1, R,  1, 1, 0);  // held add issues
    add(0, 0, 1, LW,  2, 0,  5,  1, 1, LW, 1, 1, 0);  // lw x5
    add(0, 0, 1, LW,  6, 5,  7,  1, 1, LW, 1, 1, 0);  // rs2 field unused by lw
    add(0, 0, 1, LW,  1, 0,  0,  1, 1, LW, 1, 1, 0);  // lw x0
    add(0, 0, 1, R,   0, 0,  8,  1, 1, R,  1, 1, 0);  // reading x0 never stalls
    add(0, 0, 1, LW,  1, 0,  9,  1, 1, LW, 1, 1, 0);  // lw x9
    add(0, 1, 1, SW,  2, 9,  0,  1, 0, 0,  0, 1, 1);  // flush beats load-use
    add(0, 0, 1, LW,  1, 0,  9,  1, 1, LW, 1, 1, 1);  // lw x9
    add(0, 0, 1, SW,  2, 9,  0,  0, 0, 0,  0, 2, 1);  // store data hazard: bubble
    add(0, 0, 1, SW,  2, 9,  0,  1, 1, SW, 1, 2, 1);  // store issues
    add(0, 0, 1, LW,  3, 0, 11,  1, 1, LW, 1, 2, 1);  // lw x11
    add(1, 1, 1, R,  11, 0, 12,  0, 1, LW, 1, 2, 1);  // hold freezes, flush ignored
    add(1, 1, 1, R,  11, 0, 12,  0, 1, LW, 1, 2, 1);
    add(1, 1, 1, R,  11, 0, 12,  0, 1, LW, 1, 2, 1);
    add(0, 1, 1, R,  11, 0, 12,  1, 0, 0,  0, 2, 2);  // flush applies once on release
    add(0, 0, 1, R,  11, 0, 12,  1, 1, R,  1, 2, 2);  // EX empty, no stall
    add(0, 0, 0, R,   1, 2, 13,  1, 0, 0,  1, 2, 2);  // invalid ID masks ctrl

    t.hold = 0; t.flush = 0; t.vld = 0; t.ctrl = 0; t.rs1 = 0; t.rs2 = 0; t.rd = 0;
    drive(t, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_ex_valid", 32'(ex_valid), 0);
    chk("reset_ex_ctrl", 32'(ex_ctrl), 0);
    chk("reset_bubble_cnt", 32'(bubble_cnt), 0);
    chk("reset_flush_cnt", 32'(flush_cnt), 0);

    di = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      t = vecs[i];
      @(negedge clk);
      drive(t, i);
      #1;
      chk($sformatf("v%0d_pc_write", i), 32'(pc_write), 32'(t.exp_pcw));
      chk($sformatf("v%0d_ifid_write", i), 32'(ifid_write), 32'(t.exp_pcw));
      @(posedge clk);
      #1;
      if (!t.hold) di = i;
      chk($sformatf("v%0d_ex_valid", i), 32'(ex_valid), 32'(t.exp_v));
      chk($sformatf("v%0d_ex_ctrl", i), 32'(ex_ctrl), 32'(t.exp_ctrl));
      chk($sformatf("v%0d_bubble_cnt", i), 32'(bubble_cnt), 32'(t.exp_bub));
      chk($sformatf("v%0d_flush_cnt", i), 32'(flush_cnt), 32'(t.exp_fl));
      if (t.chk_data) begin
        ep = pc_of(di);
        chk($sformatf("v%0d_ex_rd", i), 32'(ex_rd), 32'(vecs[di].rd));
        chk($sformatf("v%0d_ex_rs1", i), 32'(ex_rs1), 32'(vecs[di].rs1));
        chk($sformatf("v%0d_ex_rs2", i), 32'(ex_rs2), 32'(vecs[di].rs2));
        chk($sformatf("v%0d_ex_pc", i), ex_pc, ep);
        chk($sformatf("v%0d_ex_rs1_data", i), ex_rs1_data, {16'hA5A5, ep[15:0]});
        chk($sformatf("v%0d_ex_rs2_data", i), ex_rs2_data, ~ep);
        chk($sformatf("v%0d_ex_imm", i), ex_imm, ep ^ 32'h00FF00FF);
        chk($sformatf("v%0d_ex_funct3", i), 32'(ex_funct3), 32'(ep[4:2]));
        chk($sformatf("v%0d_ex_funct7_5", i), 32'(ex_funct7_5), 32'(ep[2]));
      end
    end

    // Eight more flushes: 3-bit counter pins at 7, 16-bit one keeps counting.
    t.hold = 0; t.flush = 1; t.vld = 1; t.ctrl = R; t.rs1 = 1; t.rs2 = 2; t.rd = 3;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      drive(t, 30);
    end
    @(posedge clk);
    #1;
    chk("sat_flush_cnt_small", 32'(s_flush_cnt), 7);
    chk("sat_flush_cnt_wide", 32'(flush_cnt), 10);
    chk("sat_bubble_cnt_small", 32'(s_bubble_cnt), 2);
    @(negedge clk);
    t.hold = 1;
    drive(t, 31);
    @(posedge clk);
    #1;
    chk("hold_flush_cnt_frozen", 32'(flush_cnt), 10);
    chk("hold_flush_cnt_small", 32'(s_flush_cnt), 7);

    // Mid-stream asynchronous reset with an R-type sitting in EX.
    @(negedge clk);
    t.hold = 0; t.flush = 0;
    drive(t, 32);
    @(posedge clk);
    #1;
    chk("pre_reset_ex_ctrl", 32'(ex_ctrl), 32'(R));
    @(negedge clk);
    hold  = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_ex_ctrl", 32'(ex_ctrl), 0);
    chk("async_reset_ex_valid", 32'(ex_valid), 0);
    chk("async_reset_bubble_cnt", 32'(bubble_cnt), 0);
    chk("async_reset_flush_cnt", 32'(flush_cnt), 0);
    chk("async_reset_pc_write", 32'(pc_write), 1);
    chk("async_reset_ifid_write", 32'(ifid_write), 1);
    @(negedge clk);
    reset = 1'b0;
    hold  = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_ex_ctrl", 32'(ex_ctrl), 32'(R));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the 5-stage RISC-V core, sitting directly downstream of the main decode controller. It registers the 8-bit control bundle, operands, immediate and register indices into the EX stage. It also detects load-use hazards, inserting a bubble and freezing PC/IF-ID, and applies branch flushes. Free-running bubble and flush counters support performance debug.

## Interface
- XLEN, 32, datapath width
- RA_W, 5, register-index width
- CNT_W, 16, width of performance counters
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- hold  in  1  global freeze (memory stall); highest priority after reset
- flush  in  1  branch taken in EX/MEM; kill instructions in ID and EX
- id_valid  in  1  ID holds a real instruction
- id_ctrl  in  8  {alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op[1:0]}, MSB first
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN each  decode-stage values
- id_rs1, id_rs2, id_rd  in  RA_W each  register indices
- id_funct3  in  3;  id_funct7_5  in  1  ALU-control inputs
- ex_valid  out  1;  ex_ctrl  out  8;  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN;  ex_rs1, ex_rs2, ex_rd  out  RA_W;  ex_funct3  out  3;  ex_funct7_5  out  1  registered EX-stage copies
- pc_write  out  1  0 = hold PC
- ifid_write  out  1  0 = hold IF/ID register
- bubble_cnt, flush_cnt  out  CNT_W  saturating event counters

## Operation
- Hazard (combinational): load_use = ex_valid & ex_ctrl.mem_read & (ex_rd != 0) & id_valid & ((ex_rd == id_rs1) | (uses_rs2 & ex_rd == id_rs2)); uses_rs2 = ~id_ctrl.alu_src | id_ctrl.mem_write.
- stall = load_use & ~flush. pc_write = ifid_write = ~(stall | hold).
- Register update priority, per clock edge:
  - reset: all outputs 0 (ex_valid = 0, ex_ctrl = 0, counters 0, data 0).
  - hold: every register retains value; counters unchanged; flush and stall ignored (upstream keeps flush asserted until hold drops).
  - flush: ex_valid <= 0, ex_ctrl <= 0; flush_cnt += 1.
  - stall: bubble: ex_valid <= 0, ex_ctrl <= 0; data/index fields may load freely; bubble_cnt += 1.
  - else: load all id_* into ex_*; ex_ctrl <= id_valid ? id_ctrl : 0.
- Bubble invariant: ex_valid = 0 implies ex_ctrl = 0 (no reg_write/mem_write/branch side effects).
- Counters saturate at 2^CNT_W − 1; no wrap.
- rd = x0 never causes a stall.

## Timing
- Latency 1 cycle ID→EX.
- stall, pc_write, ifid_write combinational from current-cycle inputs and registered ex_*; valid in the same cycle as the hazard.
- Load-use costs exactly one bubble: after the bubble, ex_valid = 0, so load_use clears and the held instruction issues next cycle.
- Simultaneous flush and load_use: flush wins, no stall, flush_cnt increments, bubble_cnt does not.
- Reset asserted mid-operation clears outputs immediately (asynchronous); deassertion synchronous to clk via the reset synchronizer upstream.
- pc_write/ifid_write are 1 during reset.

## Structure
- Shared package riscv_pipe_pkg: CTRL_W = 8; bit indices CTRL_ALU_SRC = 7, CTRL_MEM_TO_REG = 6, CTRL_REG_WRITE = 5, CTRL_MEM_READ = 4, CTRL_MEM_WRITE = 3, CTRL_BRANCH = 2, CTRL_ALU_OP = [1:0]; opcode constants OP_R = 7'b0110011, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011.
- One sub-module: hazard_detect (pure combinational load_use/stall); the register and counters remain in id_ex_stage.

## Test plan
- Reset: assert reset mid-stream with ex_ctrl = 8'b00100010 → ex_ctrl = 0, ex_valid = 0, counters 0 at once; pc_write = 1.
- Pass-through: R-type (id_ctrl = 8'b00100010, rs1 = 3, rs2 = 4, rd = 5) → next edge ex_ctrl = 8'b00100010, ex_rd = 5, ex_valid = 1.
- Load-use: lw x5 (8'b11110000, rd = 5) then add using rs2 = 5 → one cycle stall = 1, pc_write = 0, next EX bubble (ex_ctrl = 0), bubble_cnt = 1, add issues following cycle.
- No false stall: lw x5 then lw with rs1 = 6 and rs2 field = 5 (alu_src = 1) → no stall; lw to x0 then use x0 → no stall.
- Flush vs stall: flush = 1 concurrent with load_use → ex_ctrl = 0, pc_write = 1, flush_cnt = 1, bubble_cnt unchanged.
- Hold: hold = 1 for 3 cycles with flush = 1 → ex_* and counters frozen; on release flush applies once, flush_cnt +1; counter preset near max saturates at 0xFFFF.
